// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle pipeline results with queued mult/div results
// into one registered register-file write per cycle, and flags pending writes for decode.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clockIn,
    input  logic                    reset,
    input  logic                    pipeWrite,
    input  logic [ADDR_W-1:0]       pipeAdd,
    input  logic [DATA_W-1:0]       pipeData,
    input  logic                    mdValid,
    input  logic [ADDR_W-1:0]       mdAdd,
    input  logic [DATA_W-1:0]       mdData,
    output logic                    mdReady,
    output logic                    reWrite,
    output logic [ADDR_W-1:0]       reInAdd,
    output logic [DATA_W-1:0]       reInData,
    input  logic [ADDR_W-1:0]       chkAdd1,
    input  logic [ADDR_W-1:0]       chkAdd2,
    output logic                    pendHit1,
    output logic                    pendHit2,
    output logic [$clog2(DEPTH):0]  fifoCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  liveQ;
    logic [ADDR_W-1:0] addQ  [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W:0]    count;

    logic pipeIssue;
    logic push;
    logic pop;

    assign fifoCount = count;
    assign mdReady   = (count < FULL_COUNT);
    assign pipeIssue = pipeWrite && (pipeAdd != '0);
    assign pop       = !pipeIssue && (count != '0);
    assign push      = mdValid && mdReady && (mdAdd != '0);

    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            liveQ <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            // Later assignments win: squash, then pop-clear, then push (which re-checks the squash).
            if (pipeIssue) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (addQ[PTR_W'(i)] == pipeAdd) begin
                        liveQ[PTR_W'(i)] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                liveQ[rdPtr] <= 1'b0;
                rdPtr        <= rdPtr + 1'b1;
            end
            if (push) begin
                liveQ[wrPtr] <= !(pipeIssue && (mdAdd == pipeAdd));
                wrPtr        <= wrPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (push) begin
            addQ[wrPtr]  <= mdAdd;
            dataQ[wrPtr] <= mdData;
        end
    end

    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            reWrite  <= 1'b0;
            reInAdd  <= '0;
            reInData <= '0;
        end else if (pipeIssue) begin
            reWrite  <= 1'b1;
            reInAdd  <= pipeAdd;
            reInData <= pipeData;
        end else if (pop) begin
            reWrite  <= liveQ[rdPtr];
            reInAdd  <= addQ[rdPtr];
            reInData <= dataQ[rdPtr];
        end else begin
            reWrite  <= 1'b0;
        end
    end

    logic qHit1;
    logic qHit2;

    always_comb begin
        qHit1 = 1'b0;
        qHit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (liveQ[PTR_W'(i)] && (addQ[PTR_W'(i)] == chkAdd1)) qHit1 = 1'b1;
            if (liveQ[PTR_W'(i)] && (addQ[PTR_W'(i)] == chkAdd2)) qHit2 = 1'b1;
        end
    end

    assign pendHit1 = (chkAdd1 != '0) && (qHit1 || (reWrite && (reInAdd == chkAdd1)));
    assign pendHit2 = (chkAdd2 != '0) && (qHit2 || (reWrite && (reInAdd == chkAdd2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        pipeWrite;
    logic [4:0]  pipeAdd;
    logic [31:0] pipeData;
    logic        mdValid;
    logic [4:0]  mdAdd;
    logic [31:0] mdData;
    logic        mdReady;
    logic        reWrite;
    logic [4:0]  reInAdd;
    logic [31:0] reInData;
    logic [4:0]  chkAdd1;
    logic [4:0]  chkAdd2;
    logic        pendHit1;
    logic        pendHit2;
    logic [2:0]  fifoCount;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clockIn(clk), .reset(reset),
        .pipeWrite(pipeWrite), .pipeAdd(pipeAdd), .pipeData(pipeData),
        .mdValid(mdValid), .mdAdd(mdAdd), .mdData(mdData), .mdReady(mdReady),
        .reWrite(reWrite), .reInAdd(reInAdd), .reInData(reInData),
        .chkAdd1(chkAdd1), .chkAdd2(chkAdd2),
        .pendHit1(pendHit1), .pendHit2(pendHit2), .fifoCount(fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic checkEn = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the expected output registers.
    typedef struct {
        logic        live;
        logic [4:0]  add;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        e;
    logic        mWr   = 1'b0;
    logic [4:0]  mAdd  = '0;
    logic [31:0] mData = '0;
    logic        mIssue;
    logic        mPush;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mWr   = 1'b0;
            mAdd  = '0;
            mData = '0;
        end else begin
            mIssue = pipeWrite && (pipeAdd != 0);
            mPush  = mdValid && (mq.size() < DEPTH) && (mdAdd != 0);
            if (mIssue) begin
                mWr = 1'b1; mAdd = pipeAdd; mData = pipeData;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                mWr = e.live; mAdd = e.add; mData = e.data;
            end else begin
                mWr = 1'b0;
            end
            if (mPush) mq.push_back('{1'b1, mdAdd, mdData});
            if (mIssue) begin
                foreach (mq[i]) if (mq[i].add == pipeAdd) mq[i].live = 1'b0;
            end
        end
    end

    function automatic logic expHit(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (mWr && mAdd == a) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].add == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            check("reWrite",   64'(reWrite),   64'(mWr));
            check("reInAdd",   64'(reInAdd),   64'(mAdd));
            check("reInData",  64'(reInData),  64'(mData));
            check("fifoCount", 64'(fifoCount), 64'(mq.size()));
            check("mdReady",   64'(mdReady),   64'(mq.size() < DEPTH));
            check("pendHit1",  64'(pendHit1),  64'(expHit(chkAdd1)));
            check("pendHit2",  64'(pendHit2),  64'(expHit(chkAdd2)));
        end
    end

    // Register file as seen by the write port, committing on negedge.
    logic [31:0] obsRf [32];
    always @(negedge clk) if (reWrite) obsRf[reInAdd] <= reInData;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipeWrite = 0; pipeAdd = 0; pipeData = 0;
        mdValid = 0; mdAdd = 0; mdData = 0;
    endtask

    task automatic expOut(input string nm, input logic w, input logic [4:0] a,
                          input logic [31:0] d, input int cnt);
        check({nm, ".wr"},  64'(reWrite),   64'(w));
        if (w) begin
            check({nm, ".add"}, 64'(reInAdd),  64'(a));
            check({nm, ".dat"}, 64'(reInData), 64'(d));
        end
        check({nm, ".cnt"}, 64'(fifoCount), 64'(cnt));
    endtask

    initial begin
        idle();
        chkAdd1 = 0; chkAdd2 = 0;

        // T1: reset held with mdValid offered
        reset = 0; mdValid = 1; mdAdd = 3; mdData = 32'h33;
        tick(); checkEn = 1'b1;
        tick(); tick();
        check("T1.reWrite", 64'(reWrite), 64'd0);
        check("T1.count",   64'(fifoCount), 64'd0);
        check("T1.ready",   64'(mdReady), 64'd1);
        reset = 1; idle();
        tick();
        expOut("T1.idle", 0, 0, 0, 0);

        // T2: single pipeline write, 1-cycle latency
        pipeWrite = 1; pipeAdd = 5; pipeData = 32'hDEAD_BEEF;
        tick(); expOut("T2.wr", 1, 5, 32'hDEAD_BEEF, 0);
        idle();
        tick(); expOut("T2.off", 0, 0, 0, 0);

        // T3: pipeline priority over queued mult/div results
        pipeWrite = 1; pipeAdd = 3; pipeData = 32'h300;
        mdValid = 1; mdAdd = 8; mdData = 1;
        tick(); expOut("T3.a", 1, 3, 32'h300, 1);
        mdAdd = 9; mdData = 2;
        tick(); expOut("T3.b", 1, 3, 32'h300, 2);
        mdValid = 0;
        tick(); expOut("T3.c", 1, 3, 32'h300, 2);
        idle();
        tick(); expOut("T3.r8", 1, 8, 1, 1);
        tick(); expOut("T3.r9", 1, 9, 2, 0);
        tick(); expOut("T3.end", 0, 0, 0, 0);

        // T4: fill the FIFO, hold a fifth offer until a slot frees
        for (int i = 0; i < 4; i++) begin
            pipeWrite = 1; pipeAdd = 1; pipeData = 32'(i);
            mdValid = 1; mdAdd = 5'(10 + i); mdData = 32'h100 + 32'(i);
            tick();
        end
        check("T4.full.cnt",   64'(fifoCount), 64'd4);
        check("T4.full.ready", 64'(mdReady), 64'd0);
        mdAdd = 14; mdData = 32'h104;
        tick(); expOut("T4.hold", 1, 1, 32'd3, 4);
        pipeWrite = 0;
        tick(); expOut("T4.r10", 1, 10, 32'h100, 3);
        check("T4.ready", 64'(mdReady), 64'd1);
        tick(); expOut("T4.r11", 1, 11, 32'h101, 3);
        mdValid = 0;
        tick(); expOut("T4.r12", 1, 12, 32'h102, 2);
        tick(); expOut("T4.r13", 1, 13, 32'h103, 1);
        tick(); expOut("T4.r14", 1, 14, 32'h104, 0);
        check("T4.model.empty", 64'(mq.size()), 64'd0);
        idle(); tick();

        // T5: WAW squash of a queued entry
        mdValid = 1; mdAdd = 7; mdData = 32'h11;
        tick(); expOut("T5.q", 0, 0, 0, 1);
        idle(); pipeWrite = 1; pipeAdd = 7; pipeData = 32'h22;
        tick(); expOut("T5.pipe", 1, 7, 32'h22, 1);
        idle();
        tick(); expOut("T5.squash", 0, 0, 0, 0);
        tick();
        check("T5.rf7", 64'(obsRf[7]), 64'h22);

        // T6: pending-hit reporting and address 0
        pipeWrite = 1; pipeAdd = 2; pipeData = 32'h2;
        mdValid = 1; mdAdd = 4; mdData = 32'h44;
        chkAdd1 = 4; chkAdd2 = 0;
        tick();
        check("T6.hitQ", 64'(pendHit1), 64'd1);
        check("T6.hit0", 64'(pendHit2), 64'd0);
        idle();
        tick();
        expOut("T6.r4", 1, 4, 32'h44, 0);
        check("T6.hitOut", 64'(pendHit1), 64'd1);
        tick();
        check("T6.noHit", 64'(pendHit1), 64'd0);
        mdValid = 1; mdAdd = 0; mdData = 32'h99;
        tick();
        check("T6.r0.cnt", 64'(fifoCount), 64'd0);
        check("T6.r0.wr",  64'(reWrite), 64'd0);
        idle();

        // Randomized traffic with narrow address range to force collisions and squashes
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 199) != 0);
            pipeWrite = 1'($urandom_range(0, 1));
            pipeAdd   = 5'($urandom_range(0, 7));
            pipeData  = $urandom;
            mdValid   = ($urandom_range(0, 2) != 0);
            mdAdd     = 5'($urandom_range(0, 7));
            mdData    = $urandom;
            chkAdd1   = 5'($urandom_range(0, 7));
            chkAdd2   = 5'($urandom_range(0, 7));
            tick();
        end
        reset = 1; idle();
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
